// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encoding, idle counter
// width and default sizing.
package uart_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 1024;
    localparam int IDLE_CNT_W  = 16;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set request at or above the pointer,
// wrapping around to index 0 when nothing above the pointer is requesting.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N    = DEF_NUM_REQ,
    parameter int IDXW = $clog2(DEF_NUM_REQ)
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [IDXW-1:0] o_idx,
    output logic            o_found
);

    // Lowest set request overall is the wrap-around answer; the lowest one at or
    // above the pointer overrides it when present.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                o_idx   = IDXW'(j);
                o_found = 1'b1;
            end
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (i_req[j] && (IDXW'(j) >= i_ptr)) begin
                o_idx = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter that feeds several byte streams into a single
// UART transmitter through a one-entry output register.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       abort
);

    localparam int IDXW = $clog2(NUM_REQ);

    state_t                r_state;
    logic [IDXW-1:0]       r_ptr;
    logic [IDXW-1:0]       r_grant_id;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic [IDLE_CNT_W-1:0] r_idle_cnt;
    logic                  r_abort;

    logic [IDXW-1:0]       w_pick_idx;
    logic                  w_pick_found;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [7:0]            w_sel_data;
    logic                  w_granted;
    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_timeout;
    logic [IDXW-1:0]       w_next_ptr;
    logic [NUM_REQ-1:0]    w_ready;

    rr_pick #(
        .N    (NUM_REQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == IDXW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // Gating with rst keeps a reset edge from completing a requester handshake.
    assign w_granted  = (r_state == ST_GRANT) && !rst;
    assign w_out_free = !r_tx_valid || tx_ready;
    assign w_accept   = w_granted && w_out_free && w_sel_valid;
    assign w_timeout  = (r_state == ST_GRANT) && !w_sel_valid &&
                        (r_idle_cnt == IDLE_CNT_W'(TIMEOUT - 1));
    assign w_next_ptr = (r_grant_id == IDXW'(NUM_REQ - 1)) ? '0 : r_grant_id + IDXW'(1);

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = w_granted && w_out_free && (r_grant_id == IDXW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_idle_cnt <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        r_state    <= ST_GRANT;
                        r_grant_id <= w_pick_idx;
                        r_idle_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_accept) begin
                        r_idle_cnt <= '0;
                        if (w_sel_last) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= w_next_ptr;
                        end
                    end else if (w_timeout) begin
                        r_abort    <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_ptr      <= w_next_ptr;
                        r_idle_cnt <= '0;
                    end else if (!w_sel_valid) begin
                        r_idle_cnt <= r_idle_cnt + IDLE_CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The output byte drains independently of the FSM, so a finished packet can
    // still be waiting on the UART while the next grant is being made.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else if (w_accept) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_sel_data;
        end else if (tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign req_ready = w_ready;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state == ST_GRANT);
    assign abort     = r_abort;

endmodule
